// File: rtl/broadcast_arbiter.sv
// Round-robin scheduler for the common data bus: picks one completed
// result per cycle and drives the registered broadcast triple.
module broadcast_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int TAG_WIDTH  = 7,
    parameter int DATA_WIDTH = 32,
    parameter int PTR_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          halt,
    input  logic                          allowBroadcast,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_grant,
    output logic                          broadcastDataAvailable,
    output logic [TAG_WIDTH-1:0]          broadcastDestinationTag,
    output logic [DATA_WIDTH-1:0]         broadcastDestinationData,
    output logic [PTR_WIDTH-1:0]          rr_pointer
);

    localparam logic [PTR_WIDTH:0]   NREQ_W = (PTR_WIDTH+1)'(NUM_REQ);
    localparam logic [PTR_WIDTH-1:0] LAST   = PTR_WIDTH'(NUM_REQ-1);

    logic                  en;
    logic                  found;
    logic [PTR_WIDTH-1:0]  win;
    logic [PTR_WIDTH:0]    sum;
    logic [PTR_WIDTH-1:0]  idx;
    logic [TAG_WIDTH-1:0]  sel_tag;
    logic [DATA_WIDTH-1:0] sel_data;

    logic [PTR_WIDTH-1:0]  ptr_q, ptr_d;
    logic                  vld_q, vld_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    assign en = rst & ~halt & allowBroadcast;

    // Scan from the pointer upward, wrapping at NUM_REQ (not a power of two).
    always_comb begin
        found    = 1'b0;
        win      = '0;
        sum      = '0;
        idx      = '0;
        req_grant = '0;
        sel_tag  = '0;
        sel_data = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            sum = {1'b0, ptr_q} + (PTR_WIDTH+1)'(off);
            if (sum >= NREQ_W) begin
                sum = sum - NREQ_W;
            end
            idx = sum[PTR_WIDTH-1:0];
            if (en && !found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (found && win == PTR_WIDTH'(i)) begin
                req_grant[i] = 1'b1;
                sel_tag      = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
                sel_data     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        ptr_d  = ptr_q;
        vld_d  = vld_q;
        tag_d  = tag_q;
        data_d = data_q;
        if (!halt) begin
            vld_d = found;
            if (found) begin
                tag_d  = sel_tag;
                data_d = sel_data;
                ptr_d  = (win == LAST) ? '0 : win + PTR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q  <= '0;
            vld_q  <= 1'b0;
            tag_q  <= '0;
            data_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            vld_q  <= vld_d;
            tag_q  <= tag_d;
            data_q <= data_d;
        end
    end

    assign broadcastDataAvailable   = vld_q;
    assign broadcastDestinationTag  = tag_q;
    assign broadcastDestinationData = data_q;
    assign rr_pointer               = ptr_q;

endmodule

// File: tb/tb_broadcast_arbiter.sv
// Bench for broadcast_arbiter: directed scenarios plus random traffic
// on a 4-requester and a 3-requester instance against a queue-free model.
module tb_broadcast_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic halt;
    logic allow;
    logic chk_en;

    logic [3:0]  rv    [2];
    logic [6:0]  rtag  [2][4];
    logic [31:0] rdata [2][4];

    logic [27:0]  tag4;
    logic [127:0] dat4;
    logic [20:0]  tag3;
    logic [95:0]  dat3;

    logic [3:0]  g4;
    logic [2:0]  g3;
    logic        bv4, bv3;
    logic [6:0]  bt4, bt3;
    logic [31:0] bd4, bd3;
    logic [1:0]  p4, p3;

    int tests = 0;
    int fails = 0;

    int          m_ptr  [2] = '{0, 0};
    logic        m_bv   [2] = '{1'b0, 1'b0};
    logic [6:0]  m_tag  [2] = '{7'h0, 7'h0};
    logic [31:0] m_data [2] = '{32'h0, 32'h0};
    logic [3:0]  m_lg   [2] = '{4'h0, 4'h0};

    always #5 clk = ~clk;

    always_comb begin
        tag4 = '0;
        dat4 = '0;
        tag3 = '0;
        dat3 = '0;
        for (int i = 0; i < 4; i++) begin
            tag4[i*7 +: 7]   = rtag[0][i];
            dat4[i*32 +: 32] = rdata[0][i];
        end
        for (int i = 0; i < 3; i++) begin
            tag3[i*7 +: 7]   = rtag[1][i];
            dat3[i*32 +: 32] = rdata[1][i];
        end
    end

    broadcast_arbiter #(.NUM_REQ(4)) dut4 (
        .clk(clk), .rst(rst), .halt(halt), .allowBroadcast(allow),
        .req_valid(rv[0]), .req_tag(tag4), .req_data(dat4),
        .req_grant(g4), .broadcastDataAvailable(bv4),
        .broadcastDestinationTag(bt4), .broadcastDestinationData(bd4),
        .rr_pointer(p4)
    );

    broadcast_arbiter #(.NUM_REQ(3)) dut3 (
        .clk(clk), .rst(rst), .halt(halt), .allowBroadcast(allow),
        .req_valid(rv[1][2:0]), .req_tag(tag3), .req_data(dat3),
        .req_grant(g3), .broadcastDataAvailable(bv3),
        .broadcastDestinationTag(bt3), .broadcastDestinationData(bd3),
        .rr_pointer(p3)
    );

    function automatic int nr(int j);
        return (j == 0) ? 4 : 3;
    endfunction

    // First requester at or after ptr, going round modulo n; -1 if none.
    function automatic int pick(int n, int ptr, logic [3:0] v);
        for (int off = 0; off < n; off++) begin
            if (v[(ptr + off) % n]) return (ptr + off) % n;
        end
        return -1;
    endfunction

    function automatic logic [3:0] egrant(int j);
        int k;
        k = pick(nr(j), m_ptr[j], rv[j]);
        if (rst && !halt && allow && k >= 0) return 4'(1 << k);
        return 4'b0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < 2; j++) begin
                m_ptr[j]  <= 0;
                m_bv[j]   <= 1'b0;
                m_tag[j]  <= '0;
                m_data[j] <= '0;
                m_lg[j]   <= '0;
            end
        end else begin
            for (int j = 0; j < 2; j++) begin
                m_lg[j] <= egrant(j);
                if (!halt) begin
                    if (egrant(j) != 4'b0) begin
                        m_bv[j]   <= 1'b1;
                        m_tag[j]  <= rtag[j][pick(nr(j), m_ptr[j], rv[j])];
                        m_data[j] <= rdata[j][pick(nr(j), m_ptr[j], rv[j])];
                        m_ptr[j]  <= (pick(nr(j), m_ptr[j], rv[j]) + 1) % nr(j);
                    end else begin
                        m_bv[j] <= 1'b0;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("grant4", 64'(g4), 64'(egrant(0)));
            chk("valid4", 64'(bv4), 64'(m_bv[0]));
            chk("tag4", 64'(bt4), 64'(m_tag[0]));
            chk("data4", 64'(bd4), 64'(m_data[0]));
            chk("ptr4", 64'(p4), 64'(m_ptr[0]));
            chk("grant3", 64'({1'b0, g3}), 64'(egrant(1)));
            chk("valid3", 64'(bv3), 64'(m_bv[1]));
            chk("tag3", 64'(bt3), 64'(m_tag[1]));
            chk("data3", 64'(bd3), 64'(m_data[1]));
            chk("ptr3", 64'(p3), 64'(m_ptr[1]));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        halt   = 1'b0;
        allow  = 1'b0;
        chk_en = 1'b0;
        for (int j = 0; j < 2; j++) begin
            rv[j] = '0;
            for (int i = 0; i < 4; i++) begin
                rtag[j][i]  = '0;
                rdata[j][i] = '0;
            end
        end
        #2 rst = 1'b0;
        chk_en = 1'b1;
        cyc();
        cyc();
        rst   = 1'b1;
        allow = 1'b1;
        #1;
        chk("rst_valid", 64'(bv4), 64'd0);
        chk("rst_tag", 64'(bt4), 64'd0);
        chk("rst_data", 64'(bd4), 64'd0);
        chk("rst_ptr", 64'(p4), 64'd0);

        rv[0] = 4'b0100;
        rtag[0][2] = 7'h2A;
        rdata[0][2] = 32'hDEADBEEF;
        rv[1] = 4'b0100;
        rtag[1][2] = 7'h33;
        #1;
        chk("single_grant", 64'(g4), 64'h4);
        chk("n3_grant", 64'(g3), 64'h4);
        cyc();
        rv[0] = '0;
        rv[1] = '0;
        #1;
        chk("single_valid", 64'(bv4), 64'd1);
        chk("single_tag", 64'(bt4), 64'h2A);
        chk("single_data", 64'(bd4), 64'hDEADBEEF);
        chk("single_ptr", 64'(p4), 64'd3);
        chk("n3_ptr_wrap", 64'(p3), 64'd0);
        chk("n3_tag", 64'(bt3), 64'h33);
        cyc();
        chk("single_idle", 64'(bv4), 64'd0);

        rv[0] = 4'b0001;
        rtag[0][0] = 7'h15;
        cyc();
        rv[0] = '0;
        #1;
        chk("pre_rst_valid", 64'(bv4), 64'd1);
        chk("pre_rst_tag", 64'(bt4), 64'h15);
        rst = 1'b0;
        #1;
        chk("amid_valid", 64'(bv4), 64'd0);
        chk("amid_tag", 64'(bt4), 64'd0);
        chk("amid_data", 64'(bd4), 64'd0);
        chk("amid_ptr", 64'(p4), 64'd0);
        rv[0] = 4'b1111;
        #1;
        chk("amid_grant", 64'(g4), 64'd0);
        cyc();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rtag[0][i]  = 7'(8'h10 + i);
            rdata[0][i] = 32'hA0000000 + 32'(i);
        end
        #1;
        chk("rel_grant", 64'(g4), 64'h1);

        for (int i = 0; i < 5; i++) begin
            chk("rot_grant", 64'(g4), 64'(1 << (i % 4)));
            cyc();
            #1;
            chk("rot_valid", 64'(bv4), 64'd1);
            chk("rot_tag", 64'(bt4), 64'(8'h10 + i % 4));
            chk("rot_ptr", 64'(p4), 64'((i + 1) % 4));
        end

        allow = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("stall_grant", 64'(g4), 64'd0);
            cyc();
            #1;
            chk("stall_valid", 64'(bv4), 64'd0);
            chk("stall_ptr", 64'(p4), 64'd1);
        end

        allow = 1'b1;
        #1;
        chk("pre_halt_grant", 64'(g4), 64'h2);
        cyc();
        halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("halt_grant", 64'(g4), 64'd0);
            cyc();
            #1;
            chk("halt_valid", 64'(bv4), 64'd1);
            chk("halt_tag", 64'(bt4), 64'h11);
            chk("halt_data", 64'(bd4), 64'hA0000001);
            chk("halt_ptr", 64'(p4), 64'd2);
        end

        halt = 1'b0;
        rv[0] = 4'b0011;
        #1;
        chk("fair_grant0", 64'(g4), 64'h1);
        cyc();
        #1;
        chk("fair_ptr1", 64'(p4), 64'd1);
        chk("fair_grant1", 64'(g4), 64'h2);
        cyc();
        #1;
        chk("fair_ptr2", 64'(p4), 64'd2);
        chk("fair_tag", 64'(bt4), 64'h11);
        rv[0] = '0;

        for (int c = 0; c < 1500; c++) begin
            cyc();
            if (!rst) begin
                rst = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                rst = 1'b0;
            end
            halt  = ($urandom_range(0, 7) == 0);
            allow = ($urandom_range(0, 4) != 0);
            for (int j = 0; j < 2; j++) begin
                for (int i = 0; i < nr(j); i++) begin
                    if (!rst) begin
                        rv[j][i] = 1'b0;
                    end else if (!rv[j][i] || m_lg[j][i]) begin
                        rv[j][i]    = 1'($urandom_range(0, 1));
                        rtag[j][i]  = 7'($urandom);
                        rdata[j][i] = $urandom;
                    end
                end
            end
        end

        cyc();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
